arrow_key_conditioner: RTL and testbench

- Sits directly upstream of the menu and page logic. It turns four raw, bouncy arrow push-buttons into clean, single-event arrow commands that the consumer samples.
- Per key it synchronises, debounces, detects the press edge, and auto-repeats UP/DOWN while held.
- Events are queued in a one-deep slot. The slot is presented for exactly one program-tick window, so a consumer running at the slower program rate sees each event exactly once.

---
 rtl/arrow_key_conditioner.sv | 128 ++++++++++++
 tb/tb_arrow_key_conditioner.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_key_conditioner.sv
// Arrow key conditioner: turns four raw, bouncy arrow buttons into clean
// single-shot arrow events held for exactly one program-tick window.
// Per key: 2-FF synchroniser, debounce counter, press-edge detect, and
// auto-repeat on UP/DOWN while held. Events queue in a one-deep slot.
module arrow_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       tick_en,
    output logic       arrow_valid,
    output logic [3:0] arrow_onehot,
    output logic [3:0] btn_level
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RPT_LAST   = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RPT_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [3:0]            sync_1;
    logic [3:0]            sync_2;
    logic [3:0][DB_W-1:0]  db_cnt;
    logic [3:0][DB_W-1:0]  db_cnt_nxt;
    logic [3:0]            level_nxt;
    logic [3:0]            press;
    logic [1:0][RP_W-1:0]  rpt_cnt;
    logic [1:0][RP_W-1:0]  rpt_cnt_nxt;
    logic [1:0]            rpt_fire;
    logic [3:0]            events;
    logic [3:0]            pick;
    logic                  slot_full;
    logic [3:0]            slot_hot;

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Debounce: count consecutive cycles of disagreement, toggle level on the last one
    always_comb begin
        level_nxt  = btn_level;
        db_cnt_nxt = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (sync_2[k] != btn_level[k]) begin
                if (db_cnt[k] == DB_LAST) begin
                    level_nxt[k]  = ~btn_level[k];
                    db_cnt_nxt[k] = '0;
                end else begin
                    db_cnt_nxt[k] = db_cnt[k] + 1'b1;
                end
            end
        end
        press = level_nxt & ~btn_level;
    end

    // Debounced level and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_level <= '0;
            db_cnt    <= '0;
        end else begin
            btn_level <= level_nxt;
            db_cnt    <= db_cnt_nxt;
        end
    end

    // Auto-repeat for UP/DOWN; after the first repeat the counter reloads to
    // DELAY-PERIOD so it never has to count past DELAY
    always_comb begin
        rpt_cnt_nxt = rpt_cnt;
        rpt_fire    = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            if (!level_nxt[k] || press[k]) begin
                rpt_cnt_nxt[k] = '0;
            end else if (tick_en) begin
                if (rpt_cnt[k] == RPT_LAST) begin
                    rpt_fire[k]    = 1'b1;
                    rpt_cnt_nxt[k] = RPT_RELOAD;
                end else begin
                    rpt_cnt_nxt[k] = rpt_cnt[k] + 1'b1;
                end
            end
        end
        events = press | {2'b00, rpt_fire};
        pick   = events & (~events + 4'd1);
    end

    // Repeat counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt_nxt;
        end
    end

    // Pending slot and presentation register; a tick drains the slot and the
    // same cycle's event refills it, so nothing arriving on a tick is lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_full    <= 1'b0;
            slot_hot     <= '0;
            arrow_valid  <= 1'b0;
            arrow_onehot <= '0;
        end else begin
            if (tick_en) begin
                arrow_valid  <= slot_full;
                arrow_onehot <= slot_hot;
            end
            if (tick_en || !slot_full) begin
                slot_full <= |pick;
                slot_hot  <= pick;
            end
        end
    end

endmodule

// File: tb/tb_arrow_key_conditioner.sv
// Self-checking bench for arrow_key_conditioner with randomized press
// timing, checked against a rule-level behavioural model.
module tb_arrow_key_conditioner;

    localparam int DB = 8;
    localparam int RD = 50;
    localparam int RP = 10;
    localparam int TP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw = '0;
    logic       tick_en = 1'b0;
    logic       arrow_valid;
    logic [3:0] arrow_onehot;
    logic [3:0] btn_level;

    arrow_key_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .tick_en(tick_en),
        .arrow_valid(arrow_valid),
        .arrow_onehot(arrow_onehot),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;
    bit last_tick = 1'b0;
    int win[16];

    // behavioural model state
    bit [3:0] m_hist[$];
    int       m_run[4];
    int       m_held[4];
    bit [3:0] m_level, m_slot, m_out;
    bit       m_full, m_valid;

    task automatic model_reset();
        m_hist = {4'b0, 4'b0};
        for (int k = 0; k < 4; k++) begin m_run[k] = 0; m_held[k] = 0; end
        m_level = '0; m_slot = '0; m_out = '0; m_full = 0; m_valid = 0;
    endtask

    task automatic model_step(input bit [3:0] raw, input bit tick);
        bit [3:0] sync, nl, ev, pk;
        m_hist.push_back(raw);
        sync = m_hist.pop_front();
        nl = m_level; ev = '0; pk = '0;
        for (int k = 0; k < 4; k++) begin
            if (sync[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == DB) begin nl[k] = ~m_level[k]; m_run[k] = 0; end
            end else m_run[k] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            if (nl[k] && !m_level[k]) begin ev[k] = 1; m_held[k] = 0; end
            else if (k < 2) begin
                if (!nl[k]) m_held[k] = 0;
                else if (tick) begin
                    m_held[k]++;
                    if (m_held[k] >= RD && (m_held[k] - RD) % RP == 0) ev[k] = 1;
                end
            end
        end
        for (int k = 3; k >= 0; k--) if (ev[k]) pk = 4'b0001 << k;
        if (tick) begin m_valid = m_full; m_out = m_slot; m_full = 0; m_slot = '0; end
        if (pk != 0 && !m_full) begin m_slot = pk; m_full = 1; end
        m_level = nl;
    endtask

    // one clock: drive tick on the falling edge, advance model at the rising edge
    task automatic cycle();
        @(negedge clk);
        tick_en = (phase == 0);
        phase = (phase + 1) % TP;
        @(posedge clk);
        last_tick = tick_en;
        if (rst) model_step(btn_raw, tick_en); else model_reset();
        #1;
        if (last_tick && arrow_valid) win[arrow_onehot]++;
    endtask

    task automatic clear_win();
        for (int i = 0; i < 16; i++) win[i] = 0;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin cycle(); n++; end while (!last_tick && n < 2 * TP);
    endtask

    task automatic test_idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            n_checks++;
            if ({arrow_valid, arrow_onehot, btn_level} !== {m_valid, m_out, m_level}) begin
                n_fail++;
                $display("FAIL idle_model: got %b/%b/%b exp %b/%b/%b", arrow_valid, arrow_onehot, btn_level, m_valid, m_out, m_level);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({arrow_valid, arrow_onehot, btn_level} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%b/%b exp 0/0000/0000", arrow_valid, arrow_onehot, btn_level);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if ({arrow_valid, arrow_onehot, btn_level} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_held: got %b/%b/%b exp all zero", arrow_valid, arrow_onehot, btn_level);
            end
        end
        rst = 1'b1;
        test_idle(8);
    endtask

    task automatic test_clean_press();
        int rise_at = 0;
        clear_win();
        repeat ($urandom_range(0, 3)) cycle();
        btn_raw = 4'b0001;
        for (int i = 1; i <= 100; i++) begin
            cycle();
            if (rise_at == 0 && btn_level[0]) rise_at = i;
            n_checks++;
            if ({arrow_valid, arrow_onehot, btn_level} !== {m_valid, m_out, m_level}) begin
                n_fail++;
                $display("FAIL press_model: cyc %0d got %b/%b/%b exp %b/%b/%b", i, arrow_valid, arrow_onehot, btn_level, m_valid, m_out, m_level);
            end
        end
        n_checks++;
        if (rise_at != 10) begin
            n_fail++;
            $display("FAIL press_debounce_latency: got %0d exp 10", rise_at);
        end
        btn_raw = '0;
        test_idle(30);
        n_checks++;
        if (win[1] != 1) begin
            n_fail++;
            $display("FAIL press_window_count: got %0d exp 1", win[1]);
        end
    endtask

    task automatic test_glitch();
        clear_win();
        for (int i = 0; i < 40; i++) begin
            btn_raw = ((i / 3) % 2 == 0) ? 4'b1000 : 4'b0000;
            cycle();
            n_checks++;
            if (btn_level !== 4'b0 || arrow_valid !== 1'b0 || {arrow_valid, arrow_onehot, btn_level} !== {m_valid, m_out, m_level}) begin
                n_fail++;
                $display("FAIL glitch_quiet: cyc %0d got valid %b level %b exp 0/0000", i, arrow_valid, btn_level);
            end
        end
        btn_raw = '0;
        test_idle(12);
    endtask

    task automatic test_repeat(input int key, input int exp_windows);
        int n = 0, ticks = 0;
        clear_win();
        repeat ($urandom_range(0, 3)) cycle();
        btn_raw = 4'b0001 << key;
        while (!btn_level[key] && n < 20) begin cycle(); n++; end
        n_checks++;
        if (!btn_level[key]) begin
            n_fail++;
            $display("FAIL repeat_press_timeout: key %0d level %b exp 1", key, btn_level[key]);
        end
        n = 0;
        while (ticks < RD + 2 * RP + 1 && n < (RD + 2 * RP + 2) * TP) begin
            cycle(); n++;
            if (last_tick) ticks++;
            n_checks++;
            if ({arrow_valid, arrow_onehot, btn_level} !== {m_valid, m_out, m_level}) begin
                n_fail++;
                $display("FAIL repeat_model: key %0d got %b/%b/%b exp %b/%b/%b", key, arrow_valid, arrow_onehot, btn_level, m_valid, m_out, m_level);
            end
        end
        btn_raw = '0;
        test_idle(40);
        n_checks++;
        if (win[1 << key] != exp_windows) begin
            n_fail++;
            $display("FAIL repeat_window_count: key %0d got %0d exp %0d", key, win[1 << key], exp_windows);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        clear_win();
        repeat ($urandom_range(0, 3)) cycle();
        btn_raw = 4'b0101;
        while (btn_level == 4'b0 && n < 20) begin cycle(); n++; end
        n_checks++;
        if (btn_level !== 4'b0101) begin
            n_fail++;
            $display("FAIL simul_levels: got %b exp 0101", btn_level);
        end
        test_idle(20);
        btn_raw = '0;
        test_idle(20);
        n_checks++;
        if (win[1] != 1 || win[4] != 0) begin
            n_fail++;
            $display("FAIL simul_windows: got up %0d left %0d exp 1 0", win[1], win[4]);
        end
    endtask

    task automatic test_back_to_back();
        clear_win();
        wait_tick();
        btn_raw = 4'b1000;
        cycle();
        btn_raw = 4'b1010;
        test_idle(20);
        btn_raw = '0;
        test_idle(20);
        n_checks++;
        if (win[8] != 1 || win[2] != 0) begin
            n_fail++;
            $display("FAIL b2b_windows: got right %0d down %0d exp 1 0", win[8], win[2]);
        end
        // press edge lands exactly on a tick: presented one tick later
        wait_tick();
        cycle(); cycle();
        btn_raw = 4'b0100;
        for (int i = 0; i < 10; i++) cycle();
        n_checks++;
        if (!(last_tick && btn_level[2] && !arrow_valid)) begin
            n_fail++;
            $display("FAIL tick_edge_hold: got tick %b level %b valid %b exp 1 1 0", last_tick, btn_level[2], arrow_valid);
        end
        for (int i = 0; i < TP; i++) cycle();
        n_checks++;
        if ({arrow_valid, arrow_onehot} !== 5'b10100) begin
            n_fail++;
            $display("FAIL tick_edge_present: got %b/%b exp 1/0100", arrow_valid, arrow_onehot);
        end
        btn_raw = '0;
        test_idle(20);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_win();
        wait_tick();
        btn_raw = 4'b1000;
        cycle(); cycle(); cycle();
        btn_raw = 4'b1001;
        test_idle(11);
        n_checks++;
        if ({arrow_valid, arrow_onehot, btn_level} !== 9'b1_1000_1001 || !m_full) begin
            n_fail++;
            $display("FAIL rstmid_setup: got %b/%b/%b exp 1/1000/1001", arrow_valid, arrow_onehot, btn_level);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({arrow_valid, arrow_onehot, btn_level} !== 9'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b/%b/%b exp all zero", arrow_valid, arrow_onehot, btn_level);
        end
        btn_raw = 4'b0001;
        cycle(); cycle(); cycle();
        rst = 1'b1;
        clear_win();
        do begin cycle(); n++; end while (!btn_level[0] && n < 30);
        n_checks++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL rstmid_redebounce: got %0d exp 10", n);
        end
        test_idle(40);
        btn_raw = '0;
        test_idle(20);
        n_checks++;
        if (win[1] != 1 || win[8] != 0) begin
            n_fail++;
            $display("FAIL rstmid_windows: got up %0d right %0d exp 1 0", win[1], win[8]);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_repeat(1, 4);
        test_repeat(2, 1);
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
